ahb_csr_sub: RTL and testbench

AHB_CSR_SUB -- requirements
Module: ahb_csr_sub

---
 rtl/csr_pkg.sv | 43 ++++
 rtl/ahb_csr_irq.sv | 43 ++++
 rtl/ahb_csr_sub.sv | 166 ++++++++++++++++
 tb/tb_ahb_csr_sub.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types for the AHB CSR subordinate: register indices, AHB transfer
// and response encodings, the CSR data type and the response FSM states.
package csr_pkg;

    localparam int CSR_DATA_W   = 32;
    localparam int CSR_NUM_REGS = 6;

    typedef logic [CSR_DATA_W-1:0] csr_data_t;

    typedef enum logic [2:0] {
        CSR_ID        = 3'd0,
        CSR_CTRL      = 3'd1,
        CSR_STATUS    = 3'd2,
        CSR_SCRATCH   = 3'd3,
        CSR_IRQ_FLAGS = 3'd4,
        CSR_IRQ_MASK  = 3'd5
    } csr_idx_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_DATA = 2'd1,
        RSP_WAIT = 2'd2,
        RSP_ERR1 = 2'd3
    } rsp_state_e;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are no-ops.
    function automatic logic is_active_trans(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_csr_irq.sv
// Interrupt flag and mask registers. Flags are set by event pulses and
// cleared by writing 1; a set arriving with a clear on the same bit wins.
module ahb_csr_irq
    import csr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic [DATA_W-1:0] event_pulse,
    input  logic              flags_wr,
    input  logic              mask_wr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] flags,
    output logic [DATA_W-1:0] mask,
    output logic              irq
);

    logic [DATA_W-1:0] clear_bits;

    assign clear_bits = flags_wr ? wdata : '0;

    // Flags: clear the written ones first, then OR in new events so set wins.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            flags <= '0;
        end else begin
            flags <= (flags & ~clear_bits) | event_pulse;
        end
    end

    // Mask: plain read/write register.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            mask <= '0;
        end else if (mask_wr) begin
            mask <= wdata;
        end
    end

    assign irq = !hreset && (|(flags & mask));

endmodule

// File: rtl/ahb_csr_sub.sv
// AHB-Lite CSR subordinate with a fixed six-register map.
// Optional build macro: AHB_CSR_WAIT_STATE_EN inserts one wait state in front
// of every mapped data phase and samples read data at the end of that wait.
module ahb_csr_sub
    import csr_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] ID_VALUE = 'h4D52_0001
) (
    input  logic              hclk_i,
    input  logic              hreset_i,
    input  logic              hsel_i,
    input  logic [ADDR_W-1:0] haddr_i,
    input  logic [1:0]        htrans_i,
    input  logic              hwrite_i,
    input  logic [DATA_W-1:0] hwdata_i,
    output logic [DATA_W-1:0] hrdata_o,
    output logic              hresp_o,
    output logic              hready_o,
    input  logic [DATA_W-1:0] status_i,
    input  logic [DATA_W-1:0] event_i,
    output logic [DATA_W-1:0] ctrl_o,
    output logic              irq_o
);

`ifdef AHB_CSR_WAIT_STATE_EN
    localparam rsp_state_e MAPPED_ENTRY = RSP_WAIT;
`else
    localparam rsp_state_e MAPPED_ENTRY = RSP_DATA;
`endif

    rsp_state_e        state_q, state_d;
    logic              accept, addr_mapped;
    logic              dp_write_q, dp_err_q;
    csr_idx_e          dp_idx_q;
    logic              wr_commit, rd_active;
    logic [DATA_W-1:0] ctrl_q, scratch_q, irq_flags, irq_mask, rd_value;

    assign accept      = !hreset_i && hsel_i && is_active_trans(htrans_i) && hready_o;
    assign addr_mapped = haddr_i < ADDR_W'(CSR_NUM_REGS);

    // Capture the address-phase control for use in the following data phase.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            dp_write_q <= 1'b0;
            dp_err_q   <= 1'b0;
            dp_idx_q   <= CSR_ID;
        end else if (accept) begin
            dp_write_q <= hwrite_i;
            dp_err_q   <= !addr_mapped;
            dp_idx_q   <= addr_mapped ? csr_idx_e'(haddr_i[2:0]) : CSR_ID;
        end
    end

    // Response FSM state register.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            state_q <= RSP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a new transfer can only start where hready_o is high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RSP_IDLE, RSP_DATA: begin
                if (accept) begin
                    state_d = addr_mapped ? MAPPED_ENTRY : RSP_ERR1;
                end else begin
                    state_d = RSP_IDLE;
                end
            end
            RSP_WAIT: state_d = RSP_DATA;
            RSP_ERR1: state_d = RSP_DATA;
            default:  state_d = RSP_IDLE;
        endcase
    end

    // Bus handshake and commit strobes; reset forces a quiet OKAY bus.
    always_comb begin
        hready_o  = 1'b1;
        hresp_o   = HRESP_OKAY;
        wr_commit = 1'b0;
        rd_active = 1'b0;
        if (!hreset_i) begin
            case (state_q)
                RSP_WAIT: hready_o = 1'b0;
                RSP_ERR1: begin
                    hready_o = 1'b0;
                    hresp_o  = HRESP_ERROR;
                end
                RSP_DATA: begin
                    hresp_o   = dp_err_q ? HRESP_ERROR : HRESP_OKAY;
                    wr_commit = dp_write_q && !dp_err_q;
                    rd_active = !dp_write_q && !dp_err_q;
                end
                default: ;
            endcase
        end
    end

    // Read multiplexer over the register map.
    always_comb begin
        rd_value = '0;
        case (dp_idx_q)
            CSR_ID:        rd_value = ID_VALUE;
            CSR_CTRL:      rd_value = ctrl_q;
            CSR_STATUS:    rd_value = status_i;
            CSR_SCRATCH:   rd_value = scratch_q;
            CSR_IRQ_FLAGS: rd_value = irq_flags;
            CSR_IRQ_MASK:  rd_value = irq_mask;
            default:       rd_value = '0;
        endcase
    end

    // CTRL and SCRATCH writes; ID and STATUS writes fall through silently.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            ctrl_q    <= '0;
            scratch_q <= '0;
        end else if (wr_commit) begin
            case (dp_idx_q)
                CSR_CTRL:    ctrl_q    <= hwdata_i;
                CSR_SCRATCH: scratch_q <= hwdata_i;
                default: ;
            endcase
        end
    end

`ifdef AHB_CSR_WAIT_STATE_EN
    logic [DATA_W-1:0] rd_sample_q;

    // Sample the selected register at the end of the wait state.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            rd_sample_q <= '0;
        end else if (state_q == RSP_WAIT) begin
            rd_sample_q <= rd_value;
        end
    end

    assign hrdata_o = rd_active ? rd_sample_q : '0;
`else
    assign hrdata_o = rd_active ? rd_value : '0;
`endif

    ahb_csr_irq #(
        .DATA_W (DATA_W)
    ) u_irq (
        .hclk        (hclk_i),
        .hreset      (hreset_i),
        .event_pulse (event_i),
        .flags_wr    (wr_commit && (dp_idx_q == CSR_IRQ_FLAGS)),
        .mask_wr     (wr_commit && (dp_idx_q == CSR_IRQ_MASK)),
        .wdata       (hwdata_i),
        .flags       (irq_flags),
        .mask        (irq_mask),
        .irq         (irq_o)
    );

    assign ctrl_o = hreset_i ? '0 : ctrl_q;

endmodule

// File: tb/tb_ahb_csr_sub.sv
// Scoreboard bench for ahb_csr_sub: the driver updates an in-order register
// model and queues the expected response; a monitor pops on each completed
// data phase. Honours AHB_CSR_WAIT_STATE_EN for the expected wait count.
module tb_ahb_csr_sub;
    import csr_pkg::*;

    localparam csr_data_t ID_EXP = 32'h4D52_0001;
`ifdef AHB_CSR_WAIT_STATE_EN
    localparam int WAITS = 1;
`else
    localparam int WAITS = 0;
`endif

    typedef struct {
        csr_data_t data;
        bit        err;
        int        waits;
    } exp_t;

    logic       hclk_i   = 1'b0;
    logic       hreset_i = 1'b1;
    logic       hsel_i   = 1'b0;
    logic       hwrite_i = 1'b0;
    logic [7:0] haddr_i  = '0;
    logic [1:0] htrans_i = HTRANS_IDLE;
    csr_data_t  hwdata_i = '0;
    csr_data_t  status_i = '0;
    csr_data_t  event_i  = '0;
    csr_data_t  hrdata_o, ctrl_o;
    logic       hresp_o, hready_o, irq_o;

    int        checks = 0;
    int        errors = 0;
    exp_t      exp_q[$];
    csr_data_t m_ctrl = '0, m_scratch = '0, m_flags = '0, m_mask = '0;
    csr_data_t prev_wdata = '0;

    ahb_csr_sub dut (
        .hclk_i   (hclk_i),
        .hreset_i (hreset_i),
        .hsel_i   (hsel_i),
        .haddr_i  (haddr_i),
        .htrans_i (htrans_i),
        .hwrite_i (hwrite_i),
        .hwdata_i (hwdata_i),
        .hrdata_o (hrdata_o),
        .hresp_o  (hresp_o),
        .hready_o (hready_o),
        .status_i (status_i),
        .event_i  (event_i),
        .ctrl_o   (ctrl_o),
        .irq_o    (irq_o)
    );

    always #5 hclk_i = ~hclk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic csr_data_t modelRead(input int idx);
        case (idx)
            0:       return ID_EXP;
            1:       return m_ctrl;
            2:       return status_i;
            3:       return m_scratch;
            4:       return m_flags;
            5:       return m_mask;
            default: return '0;
        endcase
    endfunction

    function automatic void modelWrite(input int idx, input csr_data_t wd);
        case (idx)
            1:       m_ctrl    = wd;
            3:       m_scratch = wd;
            4:       m_flags   = m_flags & ~wd;
            5:       m_mask    = wd;
            default: ;
        endcase
    endfunction

    function automatic void modelReset();
        m_ctrl    = '0;
        m_scratch = '0;
        m_flags   = '0;
        m_mask    = '0;
    endfunction

    // Drive one address phase (plus previous write data) until it is accepted.
    task automatic applyStimulus(input bit sel, input bit wr, input int idx,
                                 input csr_data_t wd, input logic [1:0] trans);
        exp_t e;
        bit   rdy;
        int   n;
        hsel_i   = sel;
        hwrite_i = wr;
        haddr_i  = 8'(idx);
        htrans_i = trans;
        hwdata_i = prev_wdata;
        if (sel && trans[1]) begin
            e.err   = (idx >= CSR_NUM_REGS);
            e.waits = e.err ? 1 : WAITS;
            e.data  = '0;
            if (!e.err) begin
                if (wr) modelWrite(idx, wd);
                else    e.data = modelRead(idx);
            end
            exp_q.push_back(e);
        end
        n = 0;
        do begin
            @(negedge hclk_i);
            rdy = hready_o;
            @(posedge hclk_i);
            #1;
            n++;
        end while (!rdy && n < 20);
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL hready_timeout: hready_o stayed 0, expected 1");
        end
        prev_wdata = (sel && trans[1] && wr) ? wd : '0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 0, '0, HTRANS_IDLE);
    endtask

    // Monitor: compare each completed data phase against the queue head.
    initial begin : monitor
        bit   pending;
        int   waits;
        exp_t e;
        pending = 1'b0;
        waits   = 0;
        forever begin
            @(negedge hclk_i);
            if (hreset_i) begin
                if (pending && exp_q.size() > 0) void'(exp_q.pop_front());
                pending = 1'b0;
                waits   = 0;
            end else begin
                if (pending) begin
                    if (!hready_o) begin
                        waits++;
                        if (exp_q.size() > 0) checkOutput("wait_hresp", 32'(hresp_o), 32'(exp_q[0].err));
                    end else begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL scoreboard: data phase completed, expected no response");
                        end else begin
                            e = exp_q.pop_front();
                            checkOutput("hresp", 32'(hresp_o), 32'(e.err));
                            checkOutput("hrdata", hrdata_o, e.data);
                            checkOutput("wait_states", 32'(waits), 32'(e.waits));
                        end
                        pending = 1'b0;
                        waits   = 0;
                    end
                end
                if (hready_o && hsel_i && htrans_i[1]) pending = 1'b1;
            end
        end
    end

    initial begin : stimulus
        int r;
        // Reset: outputs must be quiet while reset is held.
        repeat (2) begin @(posedge hclk_i); #1; end
        checkOutput("rst_hready", 32'(hready_o), 32'd1);
        checkOutput("rst_hresp", 32'(hresp_o), 32'd0);
        checkOutput("rst_hrdata", hrdata_o, 32'd0);
        checkOutput("rst_ctrl_o", ctrl_o, 32'd0);
        checkOutput("rst_irq_o", 32'(irq_o), 32'd0);
        hreset_i = 1'b0;
        status_i = $urandom;

        // ID and CTRL after reset.
        applyStimulus(1'b1, 1'b0, 0, '0, HTRANS_NONSEQ);
        applyStimulus(1'b1, 1'b0, 1, '0, HTRANS_NONSEQ);
        idleCycle();

        // Four-beat burst write, then read-back.
        applyStimulus(1'b1, 1'b1, 1, 32'd1, HTRANS_NONSEQ);
        applyStimulus(1'b1, 1'b1, 2, 32'd2, HTRANS_SEQ);
        checkOutput("ctrl_o_after_burst", ctrl_o, 32'd1);
        applyStimulus(1'b1, 1'b1, 3, 32'd3, HTRANS_SEQ);
        applyStimulus(1'b1, 1'b1, 4, 32'd0, HTRANS_SEQ);
        applyStimulus(1'b1, 1'b0, 1, '0, HTRANS_NONSEQ);
        applyStimulus(1'b1, 1'b0, 2, '0, HTRANS_SEQ);
        applyStimulus(1'b1, 1'b0, 3, '0, HTRANS_SEQ);
        applyStimulus(1'b1, 1'b0, 4, '0, HTRANS_SEQ);
        idleCycle();

        // Write then immediate read of SCRATCH.
        applyStimulus(1'b1, 1'b1, 3, 32'hA5A5_A5A5, HTRANS_NONSEQ);
        applyStimulus(1'b1, 1'b0, 3, '0, HTRANS_NONSEQ);
        idleCycle();

        // Unmapped index, then CTRL still readable.
        applyStimulus(1'b1, 1'b0, 7, '0, HTRANS_NONSEQ);
        applyStimulus(1'b1, 1'b0, 1, '0, HTRANS_NONSEQ);
        idleCycle();

        // Interrupt: mask bit 0 and pulse event 0.
        applyStimulus(1'b1, 1'b1, 5, 32'd1, HTRANS_NONSEQ);
        idleCycle();
        event_i = 32'd1;
        @(posedge hclk_i); #1;
        event_i = '0;
        m_flags = m_flags | 32'd1;
        checkOutput("irq_after_event", 32'(irq_o), 32'(|(m_flags & m_mask)));

        // Clear and event in the same commit cycle: set must win.
        applyStimulus(1'b1, 1'b1, 4, 32'd1, HTRANS_NONSEQ);
        m_flags  = m_flags | 32'd1;
        hsel_i   = 1'b0;
        htrans_i = HTRANS_IDLE;
        repeat (WAITS) begin @(posedge hclk_i); #1; end
        event_i = 32'd1;
        idleCycle();
        event_i = '0;
        checkOutput("irq_set_wins", 32'(irq_o), 32'(|(m_flags & m_mask)));
        applyStimulus(1'b1, 1'b0, 4, '0, HTRANS_NONSEQ);

        // Clear with no event.
        applyStimulus(1'b1, 1'b1, 4, 32'd1, HTRANS_NONSEQ);
        idleCycle();
        checkOutput("irq_after_clear", 32'(irq_o), 32'(|(m_flags & m_mask)));
        checkOutput("irq_cleared", 32'(irq_o), 32'd0);

        // Randomised mix of transfers against the register model.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              $urandom_range(0, 9), $urandom, 2'($urandom_range(0, 1)));
            end else begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 9),
                              $urandom, 2'($urandom_range(2, 3)));
            end
        end
        idleCycle();
        checkOutput("ctrl_o_random", ctrl_o, m_ctrl);
        checkOutput("irq_o_random", 32'(irq_o), 32'(|(m_flags & m_mask)));

        // Reset during a SCRATCH write data phase drops the write.
        applyStimulus(1'b1, 1'b1, 1, 32'h55, HTRANS_NONSEQ);
        idleCycle();
        applyStimulus(1'b1, 1'b1, 3, 32'hDEAD_BEEF, HTRANS_NONSEQ);
        hsel_i   = 1'b0;
        htrans_i = HTRANS_IDLE;
        hwdata_i = 32'hDEAD_BEEF;
        hreset_i = 1'b1;
        #1;
        checkOutput("midrst_hready", 32'(hready_o), 32'd1);
        checkOutput("midrst_ctrl_o", ctrl_o, 32'd0);
        checkOutput("midrst_hrdata", hrdata_o, 32'd0);
        repeat (2) begin @(posedge hclk_i); #1; end
        hreset_i = 1'b0;
        modelReset();
        prev_wdata = '0;
        applyStimulus(1'b1, 1'b0, 3, '0, HTRANS_NONSEQ);
        applyStimulus(1'b1, 1'b0, 1, '0, HTRANS_NONSEQ);
        idleCycle();
        checkOutput("ctrl_o_post_rst", ctrl_o, 32'd0);

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
